// File: rtl/sap_microseq.sv
`default_nettype none
// ============================================================================
// Module   : sap_microseq
// Purpose  : SAP CPU microsequencer that decodes opcode, step and flags into the 18-bit control word
// Revision : 1.0 - initial release
// ============================================================================
module sap_microseq #(
  parameter int OPCODE_W    = 4,
  parameter int STEP_W      = 3,
  parameter int FIXED_STEPS = 6,
  parameter int VAR_LEN     = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                halt,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero_flag,
  input  logic                carry_flag,
  output logic [17:0]         ctrl,
  output logic [STEP_W-1:0]   step,
  output logic                instr_done,
  output logic                halted
);

  // Control word bits, MSB first: opr_in .. hlt
  localparam logic [17:0] c_OPR_IN  = 18'h20000;
  localparam logic [17:0] c_IR_OUT  = 18'h10000;
  localparam logic [17:0] c_IR_IN   = 18'h08000;
  localparam logic [17:0] c_BR_IN   = 18'h04000;
  localparam logic [17:0] c_RAM_OUT = 18'h02000;
  localparam logic [17:0] c_RAM_IN  = 18'h01000;
  localparam logic [17:0] c_MAR_IN  = 18'h00800;
  localparam logic [17:0] c_XOR_NOT = 18'h00400;
  localparam logic [17:0] c_ALU_0   = 18'h00200;
  localparam logic [17:0] c_ALU_1   = 18'h00100;
  localparam logic [17:0] c_ADD_SUB = 18'h00080;
  localparam logic [17:0] c_ALU_OUT = 18'h00040;
  localparam logic [17:0] c_ACC_OUT = 18'h00020;
  localparam logic [17:0] c_ACC_IN  = 18'h00010;
  localparam logic [17:0] c_JUMP    = 18'h00008;
  localparam logic [17:0] c_PC_OUT  = 18'h00004;
  localparam logic [17:0] c_PC_INC  = 18'h00002;
  localparam logic [17:0] c_HLT     = 18'h00001;

  localparam logic [7:0] c_T0 = 8'd0;
  localparam logic [7:0] c_T1 = 8'd1;
  localparam logic [7:0] c_T2 = 8'd2;
  localparam logic [7:0] c_T3 = 8'd3;
  localparam logic [7:0] c_T4 = 8'd4;
  localparam logic [7:0] c_FIXED_LAST = 8'(FIXED_STEPS - 1);

  localparam logic [3:0] c_OP_NOP = 4'h0;
  localparam logic [3:0] c_OP_LDA = 4'h1;
  localparam logic [3:0] c_OP_LDI = 4'h2;
  localparam logic [3:0] c_OP_STA = 4'h3;
  localparam logic [3:0] c_OP_ADD = 4'h4;
  localparam logic [3:0] c_OP_SUB = 4'h5;
  localparam logic [3:0] c_OP_AND = 4'h6;
  localparam logic [3:0] c_OP_OR  = 4'h7;
  localparam logic [3:0] c_OP_XOR = 4'h8;
  localparam logic [3:0] c_OP_NOT = 4'h9;
  localparam logic [3:0] c_OP_JMP = 4'hA;
  localparam logic [3:0] c_OP_JZ  = 4'hB;
  localparam logic [3:0] c_OP_JC  = 4'hC;
  localparam logic [3:0] c_OP_OUT = 4'hE;
  localparam logic [3:0] c_OP_HLT = 4'hF;

  logic [STEP_W-1:0] r_step;
  logic              r_halted;

  logic [7:0]  w_step8;
  logic        w_op_ok;
  logic [3:0]  w_op;
  logic [7:0]  w_last;
  logic [7:0]  w_end;
  logic [17:0] w_exec;
  logic [17:0] w_alu_sel;
  logic [17:0] w_word;
  logic        w_is_last;
  logic        w_in_range;
  logic        w_active;
  logic        w_hlt_now;

  // Step is compared in a fixed 8-bit space so corrupt high values stay visible
  assign w_step8 = 8'(r_step);

  if (OPCODE_W > 4) begin : g_op_wide
    assign w_op_ok = ~|opcode[OPCODE_W-1:4];
  end else begin : g_op_narrow
    assign w_op_ok = 1'b1;
  end

  assign w_op = w_op_ok ? opcode[3:0] : c_OP_NOP;

  always_comb begin
    w_alu_sel = '0;
    case (w_op)
      c_OP_SUB: w_alu_sel = c_ADD_SUB;
      c_OP_AND: w_alu_sel = c_ALU_0;
      c_OP_OR:  w_alu_sel = c_ALU_1;
      c_OP_XOR: w_alu_sel = c_ALU_1 | c_ALU_0;
      default:  w_alu_sel = '0;
    endcase
  end

  always_comb begin
    w_exec = '0;
    w_last = c_T2;
    case (w_op)
      c_OP_NOP: w_last = c_T1;
      c_OP_LDA: begin
        w_last = c_T3;
        if (w_step8 == c_T2)      w_exec = c_IR_OUT | c_MAR_IN;
        else if (w_step8 == c_T3) w_exec = c_RAM_OUT | c_ACC_IN;
      end
      c_OP_LDI: if (w_step8 == c_T2) w_exec = c_IR_OUT | c_ACC_IN;
      c_OP_STA: begin
        w_last = c_T3;
        if (w_step8 == c_T2)      w_exec = c_IR_OUT | c_MAR_IN;
        else if (w_step8 == c_T3) w_exec = c_ACC_OUT | c_RAM_IN;
      end
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR: begin
        w_last = c_T4;
        if (w_step8 == c_T2)      w_exec = c_IR_OUT | c_MAR_IN;
        else if (w_step8 == c_T3) w_exec = c_RAM_OUT | c_BR_IN;
        else if (w_step8 == c_T4) w_exec = c_ALU_OUT | c_ACC_IN | w_alu_sel;
      end
      c_OP_NOT: if (w_step8 == c_T2) w_exec = c_ACC_IN | c_ALU_1 | c_ALU_0 | c_XOR_NOT;
      c_OP_JMP: if (w_step8 == c_T2) w_exec = c_JUMP | c_IR_OUT;
      c_OP_JZ:  if (w_step8 == c_T2 && zero_flag)  w_exec = c_JUMP | c_IR_OUT;
      c_OP_JC:  if (w_step8 == c_T2 && carry_flag) w_exec = c_JUMP | c_IR_OUT;
      c_OP_OUT: if (w_step8 == c_T2) w_exec = c_ACC_OUT | c_OPR_IN;
      c_OP_HLT: if (w_step8 == c_T2) w_exec = c_HLT;
      default:  w_exec = '0;
    endcase
  end

  always_comb begin
    w_word = '0;
    if (w_step8 == c_T0)      w_word = c_PC_OUT | c_MAR_IN;
    else if (w_step8 == c_T1) w_word = c_PC_INC | c_RAM_OUT | c_IR_IN;
    else                      w_word = w_exec;
  end

  if (VAR_LEN != 0) begin : g_var_len
    assign w_end = w_last;
  end else begin : g_fixed_len
    assign w_end = c_FIXED_LAST;
  end

  assign w_is_last  = (w_step8 == w_end);
  assign w_in_range = (w_step8 <= w_end);
  assign w_active   = ~reset & ~halt & ~r_halted;
  assign w_hlt_now  = (w_op == c_OP_HLT) && (w_step8 == c_T2) && w_in_range;

  assign ctrl       = (w_active && w_in_range) ? w_word : '0;
  assign instr_done = w_active & w_is_last;
  assign step       = r_step;
  assign halted     = r_halted;

  // halt freezes everything, including a HLT decoded in the same cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_step   <= '0;
      r_halted <= 1'b0;
    end else if (!halt && !r_halted) begin
      if (w_hlt_now) begin
        r_halted <= 1'b1;
        r_step   <= '0;
      end else if (w_is_last || !w_in_range) begin
        r_step <= '0;
      end else begin
        r_step <= r_step + STEP_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sap_microseq.sv
`default_nettype none
// Bench for sap_microseq: directed scenarios, then random instructions against an instruction-table model.
module tb_sap_microseq;

  localparam logic [17:0] OPR_IN  = 18'h20000, IR_OUT = 18'h10000, IR_IN   = 18'h08000;
  localparam logic [17:0] BR_IN   = 18'h04000, RAM_OUT = 18'h02000, RAM_IN = 18'h01000;
  localparam logic [17:0] MAR_IN  = 18'h00800, XOR_NOT = 18'h00400, ALU_0  = 18'h00200;
  localparam logic [17:0] ALU_1   = 18'h00100, ADD_SUB = 18'h00080, ALU_OUT = 18'h00040;
  localparam logic [17:0] ACC_OUT = 18'h00020, ACC_IN  = 18'h00010, JUMP   = 18'h00008;
  localparam logic [17:0] PC_OUT  = 18'h00004, PC_INC  = 18'h00002, HLT    = 18'h00001;
  localparam logic [17:0] NONE    = 18'h00000;

  logic        clock = 1'b0;
  logic        reset, halt, zero_flag, carry_flag;
  logic [3:0]  op, op_f;
  logic [17:0] ctrl_v, ctrl_f;
  logic [2:0]  step_v, step_f;
  logic        done_v, done_f, halted_v, halted_f;

  int errors = 0;
  int checks = 0;
  int m_step [2];
  bit m_halt [2];

  always #5 clock = ~clock;

  sap_microseq #(.OPCODE_W(4), .STEP_W(3), .FIXED_STEPS(6), .VAR_LEN(1)) dut_v (
    .clock(clock), .reset(reset), .halt(halt), .opcode(op),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .ctrl(ctrl_v), .step(step_v), .instr_done(done_v), .halted(halted_v));

  sap_microseq #(.OPCODE_W(4), .STEP_W(3), .FIXED_STEPS(6), .VAR_LEN(0)) dut_f (
    .clock(clock), .reset(reset), .halt(halt), .opcode(op_f),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .ctrl(ctrl_f), .step(step_f), .instr_done(done_f), .halted(halted_f));

  // Number of steps an instruction occupies in variable-length mode
  function automatic int ilen(input logic [3:0] o);
    case (o)
      4'h0:                         return 2;
      4'h1, 4'h3:                   return 4;
      4'h4, 4'h5, 4'h6, 4'h7, 4'h8: return 5;
      default:                      return 3;
    endcase
  endfunction

  function automatic logic [17:0] uword(input logic [3:0] o, input int k, input logic z, input logic c);
    logic [17:0] sel;
    case (o)
      4'h5:    sel = ADD_SUB;
      4'h6:    sel = ALU_0;
      4'h7:    sel = ALU_1;
      4'h8:    sel = ALU_1 | ALU_0;
      default: sel = NONE;
    endcase
    if (k == 0) return PC_OUT | MAR_IN;
    if (k == 1) return PC_INC | RAM_OUT | IR_IN;
    case (o)
      4'h1: return (k == 2) ? (IR_OUT | MAR_IN) : (k == 3) ? (RAM_OUT | ACC_IN) : NONE;
      4'h2: return (k == 2) ? (IR_OUT | ACC_IN) : NONE;
      4'h3: return (k == 2) ? (IR_OUT | MAR_IN) : (k == 3) ? (ACC_OUT | RAM_IN) : NONE;
      4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
        return (k == 2) ? (IR_OUT | MAR_IN) : (k == 3) ? (RAM_OUT | BR_IN) :
               (k == 4) ? (ALU_OUT | ACC_IN | sel) : NONE;
      4'h9: return (k == 2) ? (ACC_IN | ALU_1 | ALU_0 | XOR_NOT) : NONE;
      4'hA: return (k == 2) ? (JUMP | IR_OUT) : NONE;
      4'hB: return (k == 2 && z) ? (JUMP | IR_OUT) : NONE;
      4'hC: return (k == 2 && c) ? (JUMP | IR_OUT) : NONE;
      4'hE: return (k == 2) ? (ACC_OUT | OPR_IN) : NONE;
      4'hF: return (k == 2) ? HLT : NONE;
      default: return NONE;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic z, input logic c);
    reset = r; halt = h; zero_flag = z; carry_flag = c;
    #1;
  endtask

  task automatic model_check();
    logic [3:0]  o;
    int          len;
    logic        act;
    logic [17:0] ec;
    logic        ed;
    for (int i = 0; i < 2; i++) begin
      o   = (i == 0) ? op : op_f;
      len = (i == 0) ? ilen(o) : 6;
      act = !reset && !halt && !m_halt[i];
      ec  = act ? uword(o, m_step[i], zero_flag, carry_flag) : NONE;
      ed  = act && (m_step[i] == len - 1);
      chk(i == 0 ? "v_ctrl" : "f_ctrl", 32'(i == 0 ? ctrl_v : ctrl_f), 32'(ec));
      chk(i == 0 ? "v_step" : "f_step", 32'(i == 0 ? step_v : step_f), 32'(m_step[i]));
      chk(i == 0 ? "v_done" : "f_done", 32'(i == 0 ? done_v : done_f), 32'(ed));
      chk(i == 0 ? "v_halted" : "f_halted", 32'(i == 0 ? halted_v : halted_f), 32'(m_halt[i]));
    end
  endtask

  task automatic adv();
    logic [3:0] o;
    int         len;
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      o   = (i == 0) ? op : op_f;
      len = (i == 0) ? ilen(o) : 6;
      if (reset) begin
        m_step[i] = 0;
        m_halt[i] = 0;
      end else if (!halt && !m_halt[i]) begin
        if (o == 4'hF && m_step[i] == 2) begin
          m_halt[i] = 1;
          m_step[i] = 0;
        end else if (m_step[i] >= len - 1) m_step[i] = 0;
        else m_step[i] = m_step[i] + 1;
      end
    end
    @(negedge clock);
  endtask

  // One cycle with explicit expectations on one instance plus the model comparison
  task automatic dstep(input int idx, input logic r, input logic h, input logic z, input logic c,
                       input logic [17:0] ec, input int es, input logic ed, input logic eh);
    drive(r, h, z, c);
    chk("d_ctrl", 32'(idx == 0 ? ctrl_v : ctrl_f), 32'(ec));
    chk("d_step", 32'(idx == 0 ? step_v : step_f), 32'(es));
    chk("d_done", 32'(idx == 0 ? done_v : done_f), 32'(ed));
    chk("d_halted", 32'(idx == 0 ? halted_v : halted_f), 32'(eh));
    model_check();
    adv();
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; zero_flag = 1'b0; carry_flag = 1'b0;
    op = 4'h1; op_f = 4'h2;
    @(posedge clock);
    m_step[0] = 0; m_step[1] = 0; m_halt[0] = 0; m_halt[1] = 0;
    @(negedge clock);

    dstep(0, 1, 0, 0, 0, NONE, 0, 0, 0);

    // LDA
    dstep(0, 0, 0, 0, 0, PC_OUT | MAR_IN, 0, 0, 0);
    dstep(0, 0, 0, 0, 0, PC_INC | RAM_OUT | IR_IN, 1, 0, 0);
    dstep(0, 0, 0, 0, 0, IR_OUT | MAR_IN, 2, 0, 0);
    dstep(0, 0, 0, 0, 0, RAM_OUT | ACC_IN, 3, 1, 0);

    // SUB
    op = 4'h5;
    dstep(0, 0, 0, 0, 0, PC_OUT | MAR_IN, 0, 0, 0);
    dstep(0, 0, 0, 0, 0, PC_INC | RAM_OUT | IR_IN, 1, 0, 0);
    dstep(0, 0, 0, 0, 0, IR_OUT | MAR_IN, 2, 0, 0);
    dstep(0, 0, 0, 0, 0, RAM_OUT | BR_IN, 3, 0, 0);
    dstep(0, 0, 0, 0, 0, ALU_OUT | ACC_IN | ADD_SUB, 4, 1, 0);

    // JZ taken then not taken
    op = 4'hB;
    dstep(0, 0, 0, 1, 0, PC_OUT | MAR_IN, 0, 0, 0);
    dstep(0, 0, 0, 1, 0, PC_INC | RAM_OUT | IR_IN, 1, 0, 0);
    dstep(0, 0, 0, 1, 0, JUMP | IR_OUT, 2, 1, 0);
    dstep(0, 0, 0, 0, 0, PC_OUT | MAR_IN, 0, 0, 0);
    dstep(0, 0, 0, 0, 0, PC_INC | RAM_OUT | IR_IN, 1, 0, 0);
    dstep(0, 0, 0, 0, 1, NONE, 2, 1, 0);

    // LDA frozen at T2 for three cycles
    op = 4'h1;
    dstep(0, 0, 0, 0, 0, PC_OUT | MAR_IN, 0, 0, 0);
    dstep(0, 0, 0, 0, 0, PC_INC | RAM_OUT | IR_IN, 1, 0, 0);
    for (int k = 0; k < 3; k++) dstep(0, 0, 1, 0, 0, NONE, 2, 0, 0);
    dstep(0, 0, 0, 0, 0, IR_OUT | MAR_IN, 2, 0, 0);
    dstep(0, 0, 0, 0, 0, RAM_OUT | ACC_IN, 3, 1, 0);

    // HLT: a coincident freeze wins, then the latched halt, then reset recovery
    op = 4'hF;
    dstep(0, 0, 0, 0, 0, PC_OUT | MAR_IN, 0, 0, 0);
    dstep(0, 0, 0, 0, 0, PC_INC | RAM_OUT | IR_IN, 1, 0, 0);
    dstep(0, 0, 1, 0, 0, NONE, 2, 0, 0);
    dstep(0, 0, 0, 0, 0, HLT, 2, 1, 0);
    for (int k = 0; k < 20; k++) dstep(0, 0, 0, 1, 1, NONE, 0, 0, 1);
    dstep(0, 1, 0, 0, 0, NONE, 0, 0, 1);
    dstep(0, 0, 0, 0, 0, PC_OUT | MAR_IN, 0, 0, 0);

    // Fixed-length instance running LDI
    op = 4'h0;
    drive(1, 0, 0, 0); model_check(); adv();
    dstep(1, 0, 0, 0, 0, PC_OUT | MAR_IN, 0, 0, 0);
    dstep(1, 0, 0, 0, 0, PC_INC | RAM_OUT | IR_IN, 1, 0, 0);
    dstep(1, 0, 0, 0, 0, IR_OUT | ACC_IN, 2, 0, 0);
    dstep(1, 0, 0, 0, 0, NONE, 3, 0, 0);
    dstep(1, 0, 0, 0, 0, NONE, 4, 0, 0);
    dstep(1, 0, 0, 0, 0, NONE, 5, 1, 0);
    dstep(1, 0, 0, 0, 0, PC_OUT | MAR_IN, 0, 0, 0);

    // Random instruction streams with sporadic freeze and reset
    for (int n = 0; n < 800; n++) begin
      if (m_step[0] == 0) op   = 4'($urandom_range(0, 15));
      if (m_step[1] == 0) op_f = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom));
      model_check();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
